pll_reset_ctrl: RTL
===================

// Module: pll_reset_ctrl
// PURPOSE
//  Reset/lock sequencer for the board MMCM/PLL wrappers. Runs on the free-running oscillator clock that feeds the PLL.
//  - Drives the PLL RST pin and watches its LOCKED output.
//  - Re-pulses RST on lock timeout or lock loss.
//  - Holds system reset until lock has been stable for a programmed interval.
//  - Downstream per-domain reset synchronizers consume o_sys_reset.
// PARAMETERS
//  RST_PULSE_CYCLES  16     PLL RST assertion length in i_clk cycles (>=1)
//  LOCK_TIMEOUT      65536  cycles allowed in WAIT_LOCK before RST is re-pulsed (>=2)
//  STABLE_CYCLES     1024   cycles of continuous lock required before release (>=1)
//  CNT_W             17     internal counter width; must hold max(parameters)-1
// PORTS
//  i_clk          in   1  free-running oscillator clock (PLL input clock)
//  i_reset        in   1  synchronous, active-high reset
//  i_pll_locked   in   1  PLL LOCKED, asynchronous to i_clk
//  i_sw_reset     in   1  one-cycle request to re-lock the PLL
//  o_pll_reset    out  1  to PLL RST, active-high
//  o_sys_reset    out  1  system reset, active-high
//  o_locked       out  1  lock qualified stable (RUN state)
//  o_state        out  2  0=RESET_PLL 1=WAIT_LOCK 2=STABLE 3=RUN
//  o_retry_cnt    out  8  saturating count of RST re-pulses since i_reset
// BEHAVIOUR
//  - Synchronizer: i_pll_locked passes through a 2-FF synchronizer; its output is locked_s.
//    - FSM logic uses only locked_s.
//    - Both FFs reset to 0.
//  - Reset (i_reset=1 at an edge):
//    - state=RESET_PLL, cnt=0, retry=0, sync FFs=0.
//    - o_pll_reset=1, o_sys_reset=1, o_locked=0.
//  - All outputs are registered and decoded from state:
//    - o_pll_reset = (state==RESET_PLL).
//    - o_sys_reset = (state!=RUN).
//    - o_locked = (state==RUN).
//  - RESET_PLL:
//    - cnt increments each cycle.
//    - At cnt==RST_PULSE_CYCLES-1: cnt<=0, go to WAIT_LOCK.
//    - Result: o_pll_reset is high exactly RST_PULSE_CYCLES cycles.
//  - WAIT_LOCK:
//    - If locked_s=1: cnt<=0, go to STABLE.
//    - Otherwise, at cnt==LOCK_TIMEOUT-1: cnt<=0, retry++, go to RESET_PLL.
//    - Otherwise cnt++.
//  - STABLE:
//    - If locked_s=0: cnt<=0, go to WAIT_LOCK. This is a glitch, so no retry++.
//    - Otherwise, at cnt==STABLE_CYCLES-1: go to RUN.
//    - Otherwise cnt++.
//  - RUN: if locked_s=0: cnt<=0, retry++, go to RESET_PLL. o_sys_reset rises on the following edge.
//  - Latency: with i_pll_locked held high from edge N (while in WAIT_LOCK), o_sys_reset falls at edge N+STABLE_CYCLES+2.
//  - Priority: i_reset > i_sw_reset > lock/timeout events.
//    - i_sw_reset in any state: cnt<=0, go to RESET_PLL. No retry++.
//    - i_sw_reset while already in RESET_PLL restarts the pulse.
//  - retry saturates at 8'hFF; only i_reset clears it.
//  - Reset mid-operation: i_reset in any state forces the reset values above on the next edge. No partial pulse is retained.
// CONFIGURATION
//  - PLL_RST_LOSS_CNT_EN defined:
//    - Adds port o_loss_cnt (out, 8): saturating count of RUN->RESET_PLL transitions caused by lock loss.
//    - Cleared by i_reset.
//    - Timeouts and i_sw_reset do not count.
//  - PLL_RST_LOSS_CNT_EN undefined: port and counter absent. All other behaviour is identical.
// TESTING (RST_PULSE_CYCLES=4, LOCK_TIMEOUT=32, STABLE_CYCLES=8)
//  1. Release i_reset; raise i_pll_locked 10 cycles later.
//     -> o_pll_reset high exactly 4 cycles.
//     -> o_sys_reset falls 10 cycles after locked rise.
//     -> o_locked=1, o_state=3.
//  2. Hold i_pll_locked=0.
//     -> o_pll_reset re-pulses every 36 cycles.
//     -> o_retry_cnt increments by 1 per pulse and saturates at 255 after 255 timeouts.
//  3. Drop locked for 1 cycle while in STABLE.
//     -> back to WAIT_LOCK, retry unchanged, no RST pulse.
//     -> release delayed by the restarted 8-cycle window.
//  4. Drop locked in RUN.
//     -> o_sys_reset=1 and o_pll_reset=1 within 4 cycles.
//     -> retry+1; o_loss_cnt+1 when PLL_RST_LOSS_CNT_EN is defined.
//  5. Pulse i_sw_reset in RUN, then again on cycle 2 of RESET_PLL.
//     -> o_pll_reset high 4 cycles counted from the second request.
//     -> retry unchanged.
//  6. Assert i_reset mid-STABLE and simultaneously with i_sw_reset.
//     -> reset values on the next edge; o_retry_cnt=0.

Source files
------------

// File: rtl/pll_reset_ctrl.sv
// PLL RST/LOCKED sequencer: pulses PLL RST, qualifies lock, holds system reset until lock is stable.
// Defining PLL_RST_LOSS_CNT_EN adds o_loss_cnt, a saturating count of lock losses seen in RUN.
module pll_reset_ctrl #(
  parameter int RST_PULSE_CYCLES = 16,
  parameter int LOCK_TIMEOUT     = 65536,
  parameter int STABLE_CYCLES    = 1024,
  parameter int CNT_W            = 17
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_pll_locked,
  input  logic       i_sw_reset,
  output logic       o_pll_reset,
  output logic       o_sys_reset,
  output logic       o_locked,
  output logic [1:0] o_state,
`ifdef PLL_RST_LOSS_CNT_EN
  output logic [7:0] o_retry_cnt,
  output logic [7:0] o_loss_cnt
`else
  output logic [7:0] o_retry_cnt
`endif
);

  typedef enum logic [1:0] {
    RESET_PLL = 2'd0,
    WAIT_LOCK = 2'd1,
    STABLE    = 2'd2,
    RUN       = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(RST_PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             locked_meta;
  logic             locked_s;

  // LOCKED comes from the PLL's own domain; only locked_s may feed the FSM.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      locked_meta <= 1'b0;
      locked_s    <= 1'b0;
    end else begin
      locked_meta <= i_pll_locked;
      locked_s    <= locked_meta;
    end
  end

  assign o_state = state;

  // Outputs are loaded alongside each state change so they track the new state with no extra cycle.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state       <= RESET_PLL;
      cnt         <= '0;
      o_retry_cnt <= 8'd0;
      o_pll_reset <= 1'b1;
      o_sys_reset <= 1'b1;
      o_locked    <= 1'b0;
`ifdef PLL_RST_LOSS_CNT_EN
      o_loss_cnt  <= 8'd0;
`endif
    end else if (i_sw_reset) begin
      state       <= RESET_PLL;
      cnt         <= '0;
      o_pll_reset <= 1'b1;
      o_sys_reset <= 1'b1;
      o_locked    <= 1'b0;
    end else begin
      case (state)
        RESET_PLL: begin
          if (cnt == RST_LAST) begin
            cnt         <= '0;
            state       <= WAIT_LOCK;
            o_pll_reset <= 1'b0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        WAIT_LOCK: begin
          if (locked_s) begin
            cnt   <= '0;
            state <= STABLE;
          end else if (cnt == TIMEOUT_LAST) begin
            cnt         <= '0;
            state       <= RESET_PLL;
            o_pll_reset <= 1'b1;
            if (o_retry_cnt != 8'hFF) o_retry_cnt <= o_retry_cnt + 8'd1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        STABLE: begin
          // A dropout here is treated as a glitch: re-qualify without pulsing RST.
          if (!locked_s) begin
            cnt   <= '0;
            state <= WAIT_LOCK;
          end else if (cnt == STABLE_LAST) begin
            cnt         <= '0;
            state       <= RUN;
            o_sys_reset <= 1'b0;
            o_locked    <= 1'b1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        RUN: begin
          if (!locked_s) begin
            cnt         <= '0;
            state       <= RESET_PLL;
            o_pll_reset <= 1'b1;
            o_sys_reset <= 1'b1;
            o_locked    <= 1'b0;
            if (o_retry_cnt != 8'hFF) o_retry_cnt <= o_retry_cnt + 8'd1;
`ifdef PLL_RST_LOSS_CNT_EN
            if (o_loss_cnt != 8'hFF) o_loss_cnt <= o_loss_cnt + 8'd1;
`endif
          end
        end
        default: begin
          cnt   <= '0;
          state <= RESET_PLL;
        end
      endcase
    end
  end

endmodule
